// File: rtl/bt_cmd_sched.sv
// RN-52 command sequencer: power-up into command mode, two-command init, then
// next/prev button arbitration with response timeout and bounded retry.
module bt_cmd_sched #(
  parameter int unsigned PWRUP_CYCLES = 131072,
  parameter int unsigned DB_BITS      = 16,
  parameter int unsigned TO_CYCLES    = 4194304,
  parameter int unsigned MAX_RETRY    = 2,
  parameter logic [4:0]  INIT0_ADDR   = 5'd0,
  parameter logic [3:0]  INIT0_LEN    = 4'd5,
  parameter logic [4:0]  INIT1_ADDR   = 5'd6,
  parameter logic [3:0]  INIT1_LEN    = 4'd7,
  parameter logic [4:0]  NEXT_ADDR    = 5'd14,
  parameter logic [3:0]  NEXT_LEN     = 4'd3,
  parameter logic [4:0]  PREV_ADDR    = 5'd18,
  parameter logic [3:0]  PREV_LEN     = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next_n,
  input  logic       prev_n,
  input  logic       resp_rcvd,
  output logic       cmd_n,
  output logic       send,
  output logic [4:0] cmd_start,
  output logic [3:0] cmd_len,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TMR_MAX = (PWRUP_CYCLES > TO_CYCLES) ? PWRUP_CYCLES : TO_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT0, ST_INIT1, ST_IDLE, ST_WAIT} state_e;
  typedef enum logic [1:0] {CMD_INIT0, CMD_INIT1, CMD_BTN} cmd_e;

  state_e             state_q, state_d;
  cmd_e               cur_q, cur_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RTY_W-1:0]   rty_q, rty_d;
  logic [DB_BITS-1:0] db_q, db_d;
  // bit 0 = next, bit 1 = prev
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         samp_q, samp_d;
  logic [1:0]         pend_q, pend_d;
  logic               cmd_n_q, cmd_n_d;
  logic               send_q, send_d;
  logic [4:0]         start_q, start_d;
  logic [3:0]         len_q, len_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               issue;
  logic [4:0]         iss_start;
  logic [3:0]         iss_len;
  cmd_e               iss_cmd;
  logic               resolve;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    tmr_d     = tmr_q;
    rty_d     = rty_q;
    db_d      = db_q + 1'b1;
    samp_d    = samp_q;
    pend_d    = pend_q;
    cmd_n_d   = cmd_n_q;
    send_d    = 1'b0;
    start_d   = start_q;
    len_d     = len_q;
    busy_d    = busy_q;
    err_d     = err_q;
    issue     = 1'b0;
    iss_start = '0;
    iss_len   = '0;
    iss_cmd   = CMD_BTN;
    resolve   = 1'b0;

    if (db_q == '1) begin
      samp_d = sync2_q;
      pend_d = pend_q | (samp_q & ~sync2_q);
    end

    case (state_q)
      ST_PWRUP: begin
        if (tmr_q == TMR_W'(PWRUP_CYCLES - 1)) begin
          cmd_n_d = 1'b0;
          tmr_d   = '0;
          state_d = ST_INIT0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_INIT0: begin
        issue = 1'b1; iss_start = INIT0_ADDR; iss_len = INIT0_LEN; iss_cmd = CMD_INIT0;
      end
      ST_INIT1: begin
        issue = 1'b1; iss_start = INIT1_ADDR; iss_len = INIT1_LEN; iss_cmd = CMD_INIT1;
      end
      ST_IDLE: begin
        // Clearing after the sample update drops a press that lands while still pending.
        if (pend_q[0]) begin
          issue = 1'b1; iss_start = NEXT_ADDR; iss_len = NEXT_LEN;
          pend_d[0] = 1'b0;
        end else if (pend_q[1]) begin
          issue = 1'b1; iss_start = PREV_ADDR; iss_len = PREV_LEN;
          pend_d[1] = 1'b0;
        end
      end
      ST_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (resp_rcvd) begin
          resolve = 1'b1;
        end else if (tmr_q == TMR_W'(TO_CYCLES - 1)) begin
          if (rty_q < RTY_W'(MAX_RETRY)) begin
            send_d = 1'b1;
            tmr_d  = '0;
            rty_d  = rty_q + 1'b1;
          end else begin
            err_d   = 1'b1;
            resolve = 1'b1;
          end
        end
        if (resolve) begin
          busy_d  = 1'b0;
          state_d = (cur_q == CMD_INIT0) ? ST_INIT1 : ST_IDLE;
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    if (issue) begin
      send_d  = 1'b1;
      busy_d  = 1'b1;
      start_d = iss_start;
      len_d   = iss_len;
      cur_d   = iss_cmd;
      tmr_d   = '0;
      rty_d   = '0;
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      cur_q   <= CMD_INIT0;
      tmr_q   <= '0;
      rty_q   <= '0;
      db_q    <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
      samp_q  <= '1;
      pend_q  <= '0;
      cmd_n_q <= 1'b1;
      send_q  <= 1'b0;
      start_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tmr_q   <= tmr_d;
      rty_q   <= rty_d;
      db_q    <= db_d;
      sync1_q <= {prev_n, next_n};
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      pend_q  <= pend_d;
      cmd_n_q <= cmd_n_d;
      send_q  <= send_d;
      start_q <= start_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign cmd_n     = cmd_n_q;
  assign send      = send_q;
  assign cmd_start = start_q;
  assign cmd_len   = len_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
